// File: rtl/branch_pkg.sv
// Shared encodings for the branch unit: instruction kinds, ARM condition codes,
// resolve FSM states and NZCV bit positions.
package branch_pkg;

  typedef logic [2:0] br_kind_t;

  localparam br_kind_t KIND_NONE  = 3'b000;
  localparam br_kind_t KIND_B     = 3'b001;
  localparam br_kind_t KIND_CBZ   = 3'b010;
  localparam br_kind_t KIND_CBNZ  = 3'b011;
  localparam br_kind_t KIND_BCOND = 3'b100;
  localparam br_kind_t KIND_BR    = 3'b101;
  localparam br_kind_t KIND_BL    = 3'b110;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_HS = 4'b0010;
  localparam logic [3:0] COND_LO = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_SQUASH   = 2'd2;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [63:0] sext_imm(input logic [25:0] imm);
    return {{38{imm[25]}}, imm};
  endfunction

  // 111 is a reserved encoding and behaves exactly like "none".
  function automatic logic kind_is_branch(input br_kind_t kind);
    return (kind != KIND_NONE) && (kind != 3'b111);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code check: {NZCV, cond} -> taken, zero latency.
// No flow control; AL and NV (1110/1111) both evaluate as always-taken.
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] nzcv_i,
  input  logic [3:0] cond_i,
  output logic       taken_o
);

  logic n, z, c, v;

  assign n = nzcv_i[FLAG_N];
  assign z = nzcv_i[FLAG_Z];
  assign c = nzcv_i[FLAG_C];
  assign v = nzcv_i[FLAG_V];

  always_comb begin
    taken_o = 1'b1;
    case (cond_i)
      COND_EQ: taken_o = z;
      COND_NE: taken_o = !z;
      COND_HS: taken_o = c;
      COND_LO: taken_o = !c;
      COND_MI: taken_o = n;
      COND_PL: taken_o = !n;
      COND_VS: taken_o = v;
      COND_VC: taken_o = !v;
      COND_HI: taken_o = c && !z;
      COND_LS: taken_o = !(c && !z);
      COND_GE: taken_o = (n == v);
      COND_LT: taken_o = (n != v);
      COND_GT: taken_o = !z && (n == v);
      COND_LE: taken_o = !(!z && (n == v));
      default: taken_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// EX-stage branch resolver: resolve in N, en_jump/jump/link_we in N+1, flushes N+1..N+SQUASH_CYCLES.
// No backpressure; wrong-path branches during squash are dropped. Stats counters under BRANCH_UNIT_STATS_EN.
module branch_unit
  import branch_pkg::*;
#(
  parameter int SQUASH_CYCLES = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        br_valid_i,
  input  logic [2:0]  br_kind_i,
  input  logic [63:0] br_pc_i,
  input  logic [25:0] br_imm_i,
  input  logic [63:0] br_reg_i,
  input  logic [3:0]  br_cond_i,
  input  logic        flags_we_i,
  input  logic [3:0]  flags_in_i,
  output logic [63:0] jump_o,
  output logic        en_jump_o,
  output logic        flush_if_o,
  output logic        flush_id_o,
  output logic        link_we_o,
  output logic [63:0] link_data_o,
  output logic [3:0]  flags_o
`ifdef BRANCH_UNIT_STATS_EN
  ,
  output logic [31:0] stat_taken_o,
  output logic [31:0] stat_not_taken_o
`endif
);

  localparam logic [2:0] SQUASH_LOAD = 3'(SQUASH_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] jump_q, jump_d;
  logic        link_pend_q, link_pend_d;
  logic [63:0] link_data_q, link_data_d;
  logic [3:0]  flags_q;

  logic [3:0]  eff_flags;
  logic        cond_taken;
  logic        taken;
  logic        accept;
  logic [63:0] target;

  // A flag-setting instruction finishing this cycle must be visible to a B.cond resolving now.
  assign eff_flags = flags_we_i ? flags_in_i : flags_q;

  cond_eval u_cond_eval (
    .nzcv_i (eff_flags),
    .cond_i (br_cond_i),
    .taken_o(cond_taken)
  );

  always_comb begin
    taken = 1'b0;
    case (br_kind_i)
      KIND_B, KIND_BL, KIND_BR: taken = 1'b1;
      KIND_CBZ:                 taken = (br_reg_i == 64'd0);
      KIND_CBNZ:                taken = (br_reg_i != 64'd0);
      KIND_BCOND:               taken = cond_taken;
      default:                  taken = 1'b0;
    endcase
  end

  assign target = (br_kind_i == KIND_BR) ? br_reg_i : br_pc_i + sext_imm(br_imm_i);
  assign accept = (state_q == ST_IDLE) && br_valid_i && kind_is_branch(br_kind_i);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    jump_d      = jump_q;
    link_pend_d = link_pend_q;
    link_data_d = link_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && taken) begin
          state_d     = ST_REDIRECT;
          jump_d      = target;
          link_pend_d = (br_kind_i == KIND_BL);
          link_data_d = br_pc_i + 64'd1;
        end
      end
      ST_REDIRECT: begin
        cnt_d       = SQUASH_LOAD;
        link_pend_d = 1'b0;
        state_d     = (SQUASH_LOAD == 3'd0) ? ST_IDLE : ST_SQUASH;
      end
      ST_SQUASH: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_d == 3'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      jump_q      <= 64'd0;
      link_pend_q <= 1'b0;
      link_data_q <= 64'd0;
      flags_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      jump_q      <= jump_d;
      link_pend_q <= link_pend_d;
      link_data_q <= link_data_d;
      if (flags_we_i) flags_q <= flags_in_i;
    end
  end

  // Strobes are masked by reset so a reset landing in REDIRECT never reaches the pc.
  assign en_jump_o   = (state_q == ST_REDIRECT) && !reset_i;
  assign link_we_o   = en_jump_o && link_pend_q;
  assign flush_if_o  = (state_q != ST_IDLE) && !reset_i;
  assign flush_id_o  = flush_if_o;
  assign jump_o      = jump_q;
  assign link_data_o = link_data_q;
  assign flags_o     = flags_q;

`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] stat_taken_q, stat_not_taken_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stat_taken_q     <= 32'd0;
      stat_not_taken_q <= 32'd0;
    end else if (accept) begin
      if (taken) stat_taken_q     <= stat_taken_q + 32'd1;
      else       stat_not_taken_q <= stat_not_taken_q + 32'd1;
    end
  end

  assign stat_taken_o     = stat_taken_q;
  assign stat_not_taken_o = stat_not_taken_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: directed vectors with literal expectations plus a
// cycle-count model of redirect/squash windows checked every cycle.
module tb_branch_unit;

  localparam int S = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        br_valid;
  logic [2:0]  br_kind;
  logic [63:0] br_pc;
  logic [25:0] br_imm;
  logic [63:0] br_reg;
  logic [3:0]  br_cond;
  logic        flags_we;
  logic [3:0]  flags_in;
  logic [63:0] jump;
  logic        en_jump, flush_if, flush_id, link_we;
  logic [63:0] link_data;
  logic [3:0]  flags;
`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] stat_taken, stat_not_taken;
`endif

  int checks = 0;
  int errors = 0;
  bit run = 0;

  branch_unit #(.SQUASH_CYCLES(S)) dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .br_valid_i (br_valid),
    .br_kind_i  (br_kind),
    .br_pc_i    (br_pc),
    .br_imm_i   (br_imm),
    .br_reg_i   (br_reg),
    .br_cond_i  (br_cond),
    .flags_we_i (flags_we),
    .flags_in_i (flags_in),
    .jump_o     (jump),
    .en_jump_o  (en_jump),
    .flush_if_o (flush_if),
    .flush_id_o (flush_id),
    .link_we_o  (link_we),
    .link_data_o(link_data),
    .flags_o    (flags)
`ifdef BRANCH_UNIT_STATS_EN
    ,
    .stat_taken_o    (stat_taken),
    .stat_not_taken_o(stat_not_taken)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_cond(input logic [3:0] f, input logic [3:0] c);
    bit n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = (n == v) && !z;
      default: base = 1'b1;
    endcase
    return (c[0] && c[3:1] != 3'd7) ? !base : base;
  endfunction

  function automatic bit m_taken(input logic [2:0] k, input logic [63:0] r,
                                 input logic [3:0] c, input logic [3:0] f);
    case (k)
      3'd1, 3'd5, 3'd6: return 1'b1;
      3'd2: return r == 64'd0;
      3'd3: return r != 64'd0;
      3'd4: return m_cond(f, c);
      default: return 1'b0;
    endcase
  endfunction

  int          flush_rem;   // flushed cycles remaining, counting the current one
  bit          m_en, m_lwe;
  logic [63:0] m_jump, m_ldata;
  logic [3:0]  m_flags, m_ef;
  int          m_st_t, m_st_nt;

  always @(posedge clock) begin
    if (reset) begin
      flush_rem = 0; m_en = 0; m_lwe = 0; m_jump = 0; m_ldata = 0; m_flags = 0;
      m_st_t = 0; m_st_nt = 0;
    end else begin
      m_ef = flags_we ? flags_in : m_flags;
      if (flush_rem == 0 && br_valid && br_kind >= 3'd1 && br_kind <= 3'd6) begin
        if (m_taken(br_kind, br_reg, br_cond, m_ef)) m_st_t++;
        else m_st_nt++;
      end
      if (flush_rem == 0 && br_valid && m_taken(br_kind, br_reg, br_cond, m_ef)) begin
        m_jump    = (br_kind == 3'd5) ? br_reg : br_pc + 64'(longint'($signed(br_imm)));
        m_en      = 1;
        m_lwe     = (br_kind == 3'd6);
        m_ldata   = br_pc + 64'd1;
        flush_rem = S;
      end else begin
        m_en = 0;
        m_lwe = 0;
        if (flush_rem > 0) flush_rem--;
      end
      if (flags_we) m_flags = flags_in;
    end
  end

  always @(negedge clock) begin
    if (run) begin
      chk("cyc_en_jump", 64'(en_jump), 64'(m_en && !reset));
      chk("cyc_link_we", 64'(link_we), 64'(m_lwe && !reset));
      chk("cyc_flush_if", 64'(flush_if), 64'(flush_rem > 0 && !reset));
      chk("cyc_flush_id", 64'(flush_id), 64'(flush_rem > 0 && !reset));
      chk("cyc_jump", jump, m_jump);
      chk("cyc_flags", 64'(flags), 64'(m_flags));
      if (m_lwe && !reset) chk("cyc_link_data", link_data, m_ldata);
`ifdef BRANCH_UNIT_STATS_EN
      chk("cyc_stat_taken", 64'(stat_taken), 64'(m_st_t));
      chk("cyc_stat_not_taken", 64'(stat_not_taken), 64'(m_st_nt));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    br_valid = 0; br_kind = 0; br_pc = 0; br_imm = 0; br_reg = 0; br_cond = 0;
    flags_we = 0; flags_in = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle_inputs();
  endtask

  task automatic drive(input logic [2:0] k, input logic [63:0] pc, input logic [25:0] imm,
                       input logic [63:0] r, input logic [3:0] c);
    br_valid = 1; br_kind = k; br_pc = pc; br_imm = imm; br_reg = r; br_cond = c;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    @(posedge clock); #1;
    run = 1;
    @(posedge clock); #1;
    chk("rst_en_jump", 64'(en_jump), 64'd0);
    chk("rst_flush", 64'(flush_if), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_jump", jump, 64'd0);
    reset = 0;
    step();

    // B at 100, imm -4
    drive(3'd1, 64'd100, 26'h3FFFFFC, 64'd0, 4'd0);
    step();
    chk("b_en", 64'(en_jump), 64'd1);
    chk("b_jump", jump, 64'd96);
    chk("b_flush1", 64'(flush_id), 64'd1);
    step();
    chk("b_en_off", 64'(en_jump), 64'd0);
    chk("b_flush2", 64'(flush_if), 64'd1);
    step();
    chk("b_flush_end", 64'(flush_if), 64'd0);
    chk("b_flags", 64'(flags), 64'd0);

    // CBZ taken, CBNZ with zero not taken
    drive(3'd2, 64'd200, 26'd8, 64'd0, 4'd0);
    step();
    chk("cbz_en", 64'(en_jump), 64'd1);
    chk("cbz_jump", jump, 64'd208);
    step(); step();
    drive(3'd3, 64'd300, 26'd8, 64'd0, 4'd0);
    step();
    chk("cbnz_en", 64'(en_jump), 64'd0);
    chk("cbnz_flush", 64'(flush_if), 64'd0);
    chk("cbnz_jump_hold", jump, 64'd208);

    // B.cond EQ with forwarded flags
    drive(3'd4, 64'd300, 26'd3, 64'd0, 4'b0000);
    flags_we = 1; flags_in = 4'b0100;
    step();
    chk("eq_en", 64'(en_jump), 64'd1);
    chk("eq_jump", jump, 64'd303);
    chk("eq_flags", 64'(flags), 64'b0100);
    step(); step();
    drive(3'd4, 64'd400, 26'd3, 64'd0, 4'b0001);
    flags_we = 1; flags_in = 4'b0100;
    step();
    chk("ne_en", 64'(en_jump), 64'd0);
    drive(3'd4, 64'd500, 26'h3FFFFFF, 64'd0, 4'b1100);
    flags_we = 1; flags_in = 4'b1001;
    step();
    chk("gt_en", 64'(en_jump), 64'd1);
    chk("gt_jump", jump, 64'd499);
    chk("gt_flags", 64'(flags), 64'b1001);
    step(); step();
    drive(3'd4, 64'd600, 26'd1, 64'd0, 4'b1011);
    step();
    chk("lt_en", 64'(en_jump), 64'd0);

    // BL and link write
    drive(3'd6, 64'd40, 26'd10, 64'd0, 4'd0);
    step();
    chk("bl_en", 64'(en_jump), 64'd1);
    chk("bl_jump", jump, 64'd50);
    chk("bl_link_we", 64'(link_we), 64'd1);
    chk("bl_link_data", link_data, 64'd41);
    step();
    chk("bl_link_we_off", 64'(link_we), 64'd0);
    step();

    // BR, then a wrong-path B in the REDIRECT cycle
    drive(3'd5, 64'd1000, 26'd0, 64'hFFFF_FFFF_FFFF_FFF0, 4'd0);
    step();
    chk("br_en", 64'(en_jump), 64'd1);
    chk("br_jump", jump, 64'hFFFF_FFFF_FFFF_FFF0);
    drive(3'd1, 64'd0, 26'd1, 64'd0, 4'd0);
    step();
    chk("wp_en", 64'(en_jump), 64'd0);
    chk("wp_jump", jump, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("wp_flush", 64'(flush_if), 64'd1);
    step();
    chk("wp_idle", 64'(flush_if), 64'd0);

    // Reset asserted in the REDIRECT cycle
    drive(3'd1, 64'd700, 26'd1, 64'd0, 4'd0);
    step();
    reset = 1;
    #1;
    chk("rr_en", 64'(en_jump), 64'd0);
    step();
    chk("rr_flags", 64'(flags), 64'd0);
    chk("rr_flush", 64'(flush_if), 64'd0);
    reset = 0;
    step();
    chk("rr_after_en", 64'(en_jump), 64'd0);
    chk("rr_after_flush", 64'(flush_if), 64'd0);
    chk("rr_after_jump", jump, 64'd0);

    // Randomised traffic checked by the per-cycle model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        drive(3'($urandom_range(0, 7)), {$urandom, $urandom}, 26'($urandom),
              ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom, $urandom}, 4'($urandom));
      end
      if ($urandom_range(0, 3) == 0) begin
        flags_we = 1;
        flags_in = 4'($urandom);
      end
      step();
    end

`ifdef BRANCH_UNIT_STATS_EN
    reset = 1;
    step();
    reset = 0;
    step();
    drive(3'd1, 64'd10, 26'd5, 64'd0, 4'd0);
    step();
    drive(3'd1, 64'd20, 26'd5, 64'd0, 4'd0);
    step(); step();
    drive(3'd2, 64'd30, 26'd5, 64'd0, 4'd0);
    step(); step(); step();
    drive(3'd6, 64'd40, 26'd5, 64'd0, 4'd0);
    step(); step(); step();
    drive(3'd2, 64'd50, 26'd5, 64'd5, 4'd0);
    step();
    drive(3'd4, 64'd60, 26'd5, 64'd0, 4'b0000);
    step();
    chk("stat_taken", 64'(stat_taken), 64'd3);
    chk("stat_not_taken", 64'(stat_not_taken), 64'd2);
`endif

    step();
    run = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Resolves LEGv8 control-flow instructions (B, BL, CBZ, CBNZ, B.cond, BR) in the execute stage and drives the jump interface of the program counter. Produces a one-cycle `en_jump` pulse with the target word address, squashes wrong-path instructions in IF/ID and ID/EX, and holds the NZCV flag register consumed by B.cond. Sits between the EX stage and the `pc` block.

## Interface
- `SQUASH_CYCLES`, 2: cycles `flush_if`/`flush_id` stay high after a taken branch (1..7).
- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `br_valid` in 1: EX-stage instruction is valid.
- `br_kind` in 3: 000 none, 001 B, 010 CBZ, 011 CBNZ, 100 B.cond, 101 BR, 110 BL; 111 treated as none.
- `br_pc` in 64: word address of the branch instruction.
- `br_imm` in 26: signed word offset, already sign-extended semantics (bit 25 = sign).
- `br_reg` in 64: Rt value (CBZ/CBNZ) or Rn word address (BR).
- `br_cond` in 4: ARM condition code for B.cond.
- `flags_we` in 1: flag-setting instruction completes this cycle.
- `flags_in` in 4: {N,Z,C,V} written when `flags_we`.
- `jump` out 64: target word address to `pc`.
- `en_jump` out 1: redirect pulse to `pc`.
- `flush_if`, `flush_id` out 1: squash IF/ID and ID/EX registers.
- `link_we` out 1, `link_data` out 64: write X30 with `br_pc + 1` for BL.
- `flags` out 4: current NZCV register.

## Operation
- Target: B/BL/CBZ/CBNZ/B.cond = `br_pc + sext64(br_imm)` mod 2^64; BR = `br_reg` unmodified. Word addresses throughout; no shift.
- Taken: B, BL, BR always; CBZ iff `br_reg == 0`; CBNZ iff `br_reg != 0`; B.cond iff condition true.
- Conditions: EQ Z, NE !Z, HS C, LO !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !(C&!Z), GE N==V, LT N!=V, GT !Z&(N==V), LE !(!Z&(N==V)), 1110/1111 always.
- Flag forwarding: if `flags_we` and a B.cond resolve in the same cycle, evaluate against `flags_in`, not the stale register.
- FSM `IDLE -> REDIRECT -> SQUASH -> IDLE`:
  - IDLE: taken valid branch registers target, goes REDIRECT. Not-taken: stay IDLE, no outputs.
  - REDIRECT (1 cycle): `en_jump=1`, `jump`=target, flushes high, load squash counter with `SQUASH_CYCLES-1`; if 0 go IDLE else SQUASH.
  - SQUASH: flushes high, decrement; at 0 go IDLE.
- `br_valid` in REDIRECT/SQUASH is wrong-path: ignored, no link write, no stats. `flags_we` is always honoured.
- BL: `link_we` pulses with `en_jump`; `link_data = br_pc + 1`.
- Reset: state IDLE, counter 0, `flags=0000`, `jump=0`, all strobes 0; reset mid-REDIRECT/SQUASH aborts with no `en_jump`.

## Timing
- Resolve in cycle N -> `en_jump`, `jump`, `link_we` high only in N+1; flushes high N+1..N+`SQUASH_CYCLES`.
- `pc` samples `jump` on the rising edge ending N+1; `jump` holds its value afterwards until next taken branch.
- `flags` updates the edge after `flags_we`.
- Back-to-back: next branch accepted earliest in cycle N+`SQUASH_CYCLES`+1.

## Configuration
- `BRANCH_UNIT_STATS_EN` defined: adds 32-bit outputs `stat_taken`, `stat_not_taken`, counting accepted (IDLE-state, valid, kind != none) branches, wrap at 2^32, cleared by `reset`.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package `branch_pkg`: `br_kind` encodings, condition-code constants, FSM state encoding, flag bit indices.
- Sub-module `cond_eval`: combinational, {NZCV, cond} -> taken bit.

## Test plan
- B at `br_pc=100`, `br_imm=-4` -> next cycle `en_jump=1`, `jump=96`; flushes 2 cycles; `flags` unchanged.
- CBZ with `br_reg=0` then (after squash) CBNZ with `br_reg=0` -> first redirects, second no `en_jump`, no flushes.
- `flags_we=1`, `flags_in=0100` same cycle as B.cond EQ -> taken; same with NE -> not taken; GT with flags 1001 -> taken.
- BL at `br_pc=40`, imm 10 -> `jump=50`, `link_we=1`, `link_data=41` in same cycle; BR with `br_reg=0xFFFF_FFFF_FFFF_FFF0` -> `jump` equal.
- Taken branch followed next cycle by valid B -> second ignored; `reset` in REDIRECT cycle -> `en_jump` not asserted, `flags=0`.
- With `BRANCH_UNIT_STATS_EN`: 3 taken, 2 not-taken, 1 wrong-path -> `stat_taken=3`, `stat_not_taken=2`.
